aes_128_inv_ram: RTL and testbench

AES-128 inverse cipher (decryption) core. It is the receive-side counterpart to the 128-bit, BRAM S-box, 3-cycle-round encryptor.
- Takes one 128-bit ciphertext block and fetches round keys 10..0 from an external round-key store through a read-address port.
- Returns the 128-bit plaintext after a fixed latency.
- Inverse S-box lives in 16 synchronous-read BRAM/ROM instances, one per state byte.

---
 rtl/aes_128_inv_ram.sv | 220 ++++++++++++++++++++++
 tb/tb_aes_128_inv_ram.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_inv_ram.sv
// ---------------------------------------------------------------------------
// aes_128_inv_ram
// AES-128 inverse cipher (decryption) core with a 3-cycle round. The inverse
// S-box is held in 16 synchronous-read ROMs, one per state byte. Round keys
// 10..0 are fetched from an external asynchronous-read store via key_addr.
//
// Round schedule after the load cycle (rk10 AddRoundKey):
//   SUB  present InvShiftRows(state) bytes as ROM addresses
//   CAP  ROM data valid, capture into sub register
//   MIX  AddRoundKey, then InvMixColumns (skipped in the final round)
//
// Parameters:
//   NR        number of rounds, must be 10
//   KEY_AW    width of key_addr
//   SBOX_FILE name of the inverse S-box image for flows that load ROMs from
//             a file; this source builds identical contents at elaboration
//             from the GF(2^8) definition, so no external file is required
//
// Ports:
//   clk          system clock, rising edge
//   kill         asynchronous active-low reset
//   input_data   ciphertext block, byte 0 = bits [127:120]
//   input_en     ciphertext strobe, taken only while ready=1
//   key_round    round key for key_addr, valid in the same cycle
//   key_addr     registered round-key index (10..0)
//   output_data  plaintext, held until the next result
//   output_en    one-cycle pulse marking a new output_data
//   ready        core idle, input_en will be accepted
//   drop         (AES_INV_DROP_FLAG_EN only) pulse after an ignored input_en
//   drop_cnt     (AES_INV_DROP_FLAG_EN only) saturating count of drops
//
// Optional feature macro: AES_INV_DROP_FLAG_EN
// ---------------------------------------------------------------------------
module aes_128_inv_ram #(
    parameter int    NR        = 10,
    parameter int    KEY_AW    = 4,
    parameter string SBOX_FILE = "inv_sbox.mem"
) (
    input  logic              clk,
    input  logic              kill,
    input  logic [127:0]      input_data,
    input  logic              input_en,
    input  logic [127:0]      key_round,
    output logic [KEY_AW-1:0] key_addr,
    output logic [127:0]      output_data,
    output logic              output_en,
    output logic              ready
`ifdef AES_INV_DROP_FLAG_EN
    ,
    output logic              drop,
    output logic [15:0]       drop_cnt
`endif
);

    if (NR != 10) begin : g_nr_check
        $error("aes_128_inv_ram: NR=%0d unsupported, only 10 rounds (sbox image %s)", NR, SBOX_FILE);
    end

    typedef enum logic [2:0] {IDLE, SUB, CAP, MIX, DONE} state_e;

    // GF(2^8) multiply, reduction polynomial 0x11B
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128 (0 maps to 0)
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gfMul(sq, sq);
            acc = gfMul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse S-box = inverse affine map followed by field inversion
    function automatic logic [2047:0] buildInvSbox();
        logic [2047:0] t;
        logic [7:0]    y;
        logic [7:0]    b;
        t = '0;
        for (int v = 0; v < 256; v++) begin
            y = 8'(v);
            b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
            t[8*v +: 8] = gfInv(b);
        end
        return t;
    endfunction

    localparam logic [2047:0] INV_SBOX = buildInvSbox();

    // Source byte for output byte i under InvShiftRows (row r rotates right by r)
    function automatic int shiftSrc(input int i);
        int r;
        int c;
        r = i % 4;
        c = i / 4;
        return r + 4 * ((c - r + 4) % 4);
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
            r[119-32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
            r[111-32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
            r[103-32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
        end
        return r;
    endfunction

    state_e              fsm_q, fsm_d;
    logic [KEY_AW-1:0]   round_q, round_d;
    logic [127:0]        blk_q, blk_d;
    logic [127:0]        sub_q;
    logic [127:0]        rom_q;
    logic [127:0]        outData_q, outData_d;
    logic [127:0]        mixIn;

    assign mixIn = sub_q ^ key_round;

    // The round counter doubles as key_addr; it rests at NR whenever idle so
    // rk10 is already on key_round when a block arrives.
    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            fsm_q     <= IDLE;
            round_q   <= KEY_AW'(NR);
            blk_q     <= '0;
            sub_q     <= '0;
            outData_q <= '0;
        end else begin
            fsm_q     <= fsm_d;
            round_q   <= round_d;
            blk_q     <= blk_d;
            outData_q <= outData_d;
            if (fsm_q == CAP) sub_q <= rom_q;
        end
    end

    // 16 byte ROMs with registered output: addresses are valid in SUB and
    // the data is available during CAP.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            rom_q[127-8*i -: 8] <= INV_SBOX[{blk_q[127-8*shiftSrc(i) -: 8], 3'b000} +: 8];
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        round_d   = round_q;
        blk_d     = blk_q;
        outData_d = outData_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (input_en) begin
                    blk_d   = input_data ^ key_round;
                    round_d = KEY_AW'(NR - 1);
                    fsm_d   = SUB;
                end else begin
                    fsm_d = IDLE;
                end
            end
            SUB: fsm_d = CAP;
            CAP: fsm_d = MIX;
            MIX: begin
                if (round_q != '0) begin
                    blk_d   = invMixColumns(mixIn);
                    round_d = round_q - 1'b1;
                    fsm_d   = SUB;
                end else begin
                    outData_d = mixIn;
                    round_d   = KEY_AW'(NR);
                    fsm_d     = DONE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign key_addr    = round_q;
    assign output_data = outData_q;
    assign output_en   = (fsm_q == DONE);
    assign ready       = (fsm_q == IDLE) || (fsm_q == DONE);

`ifdef AES_INV_DROP_FLAG_EN
    logic        drop_q;
    logic [15:0] dropCnt_q;

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            drop_q    <= 1'b0;
            dropCnt_q <= '0;
        end else begin
            drop_q <= input_en & ~ready;
            if (input_en && !ready && dropCnt_q != 16'hFFFF) dropCnt_q <= dropCnt_q + 16'd1;
        end
    end

    assign drop     = drop_q;
    assign drop_cnt = dropCnt_q;
`endif

endmodule

// File: tb/tb_aes_128_inv_ram.sv
// ---------------------------------------------------------------------------
// tb_aes_128_inv_ram
// Directed bench for aes_128_inv_ram. A forward AES-128 model (key expansion
// and encryption) serves round keys and produces ciphertexts; the FIPS-197
// C.1 vector is checked against its published values.
// ---------------------------------------------------------------------------
module tb_aes_128_inv_ram;

    localparam int KEY_AW = 4;

    logic              clk = 1'b0;
    logic              kill;
    logic [127:0]      input_data;
    logic              input_en;
    logic [127:0]      key_round;
    logic [KEY_AW-1:0] key_addr;
    logic [127:0]      output_data;
    logic              output_en;
    logic              ready;
`ifdef AES_INV_DROP_FLAG_EN
    logic              drop;
    logic [15:0]       drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox [256];
    logic [127:0] modelRk [11];
    logic [127:0] rkTable [16];

    aes_128_inv_ram #(.NR(10), .KEY_AW(KEY_AW)) dut (
        .clk         (clk),
        .kill        (kill),
        .input_data  (input_data),
        .input_en    (input_en),
        .key_round   (key_round),
        .key_addr    (key_addr),
        .output_data (output_data),
        .output_en   (output_en),
        .ready       (ready)
`ifdef AES_INV_DROP_FLAG_EN
        ,
        .drop        (drop),
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External asynchronous-read round-key store
    assign key_round = rkTable[key_addr];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] gInv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < 254; k++) r = gmul(r, x);
        return r;
    endfunction

    function automatic logic [127:0] aesEncrypt(input logic [127:0] pt);
        logic [127:0] s;
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ modelRk[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
            for (int i = 0; i < 16; i++) t[i] = b[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
                    t[4*c+3] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[i];
            s = s ^ modelRk[rnd];
        end
        return s;
    endfunction

    task automatic expandKey(input logic [127:0] key);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        modelRk[0] = key;
        rc = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            {w0, w1, w2, w3} = modelRk[i-1];
            t  = {w3[23:0], w3[31:24]};
            t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            modelRk[i] = {w0, w1, w2, w3};
            rc = xtime(rc);
        end
    endtask

    task automatic loadKeyStore();
        for (int i = 0; i < 16; i++) rkTable[i] = (i <= 10) ? modelRk[i] : '0;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one ciphertext in the current cycle, optionally pokes input_en
    // while busy, and follows the block to its output_en pulse (bounded).
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] expPt, input string tag,
                                 input int pokeA, input int pokeB);
        int lat;
        int keyBad;
        int drops;
        int expDrops;
        lat = 0;
        keyBad = 0;
        drops = 0;
        input_data = ct;
        input_en = 1'b1;
        @(negedge clk);
        lat = 1;
        while (output_en !== 1'b1 && lat < 40) begin
            input_en   = (lat == pokeA) || (lat == pokeB);
            input_data = input_en ? 128'hdeadbeef_01234567_89abcdef_feedface : ct;
            if (key_addr !== 4'(9 - (lat - 1) / 3)) keyBad++;
            @(negedge clk);
            lat++;
`ifdef AES_INV_DROP_FLAG_EN
            drops += int'(drop);
`endif
        end
        input_en = 1'b0;
        input_data = '0;
        expDrops = 0;
`ifdef AES_INV_DROP_FLAG_EN
        expDrops = int'(pokeA > 0) + int'(pokeB > 0);
`endif
        checkOutput({tag, "_latency"}, 128'(lat), 128'(31));
        checkOutput({tag, "_data"}, output_data, expPt);
        checkOutput({tag, "_keyaddr_seq_bad"}, 128'(keyBad), 128'(0));
        checkOutput({tag, "_keyaddr_done"}, 128'(key_addr), 128'(10));
        checkOutput({tag, "_drops"}, 128'(drops), 128'(expDrops));
    endtask

    initial begin
        logic [127:0] ct1, ct2, pt3, ct3, ct6;
        logic [7:0]   b;
        int           seen;

        for (int v = 0; v < 256; v++) begin
            b = gInv(8'(v));
            sbox[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        expandKey(128'h000102030405060708090a0b0c0d0e0f);
        loadKeyStore();

        // 1: reset then idle
        kill = 1'b0;
        input_en = 1'b0;
        input_data = '0;
        repeat (2) @(negedge clk);
        kill = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_ready", 128'(ready), 128'(1));
        checkOutput("reset_key_addr", 128'(key_addr), 128'(10));
        checkOutput("reset_output_en", 128'(output_en), 128'(0));
        checkOutput("reset_output_data", output_data, 128'h0);

        // 2: FIPS-197 C.1
        $display("[TB] FIPS-197 C.1 decrypt");
        ct1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        applyStimulus(ct1, 128'h00112233445566778899aabbccddeeff, "fips", -1, -1);

        // 3: back-to-back, driven in the output_en cycle
        ct2 = aesEncrypt(128'h0);
        applyStimulus(ct2, 128'h0, "b2b", -1, -1);

        // 4: input_en pulses while busy are ignored
        applyStimulus(ct1, 128'h00112233445566778899aabbccddeeff, "busy_poke", 5, 12);
`ifdef AES_INV_DROP_FLAG_EN
        checkOutput("drop_cnt", 128'(drop_cnt), 128'(2));
`endif
        repeat (3) @(negedge clk);
        checkOutput("hold_output_data", output_data, 128'h00112233445566778899aabbccddeeff);
        checkOutput("hold_output_en", 128'(output_en), 128'(0));

        // 5: kill mid-block
        input_data = ct1;
        input_en = 1'b1;
        @(negedge clk);
        input_en = 1'b0;
        repeat (14) @(negedge clk);
        kill = 1'b0;
        #1;
        checkOutput("kill_ready", 128'(ready), 128'(1));
        checkOutput("kill_key_addr", 128'(key_addr), 128'(10));
        checkOutput("kill_output_data", output_data, 128'h0);
        @(negedge clk);
        kill = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (output_en === 1'b1) seen++;
        end
        checkOutput("kill_no_output_en", 128'(seen), 128'(0));
        pt3 = 128'h0123456789abcdeffedcba9876543210;
        ct3 = aesEncrypt(pt3);
        applyStimulus(ct3, pt3, "after_kill", -1, -1);

        // 6: constant round key for every round
        for (int i = 0; i < 11; i++) modelRk[i] = 128'hff00ff00ff00ff00ff00ff00ff00ff00;
        loadKeyStore();
        ct6 = aesEncrypt(128'h00000000000000000000000000000001);
        @(negedge clk);
        applyStimulus(ct6, 128'h00000000000000000000000000000001, "const_key", -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
